// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported word memory between the fetch port and the
// data port. Data has priority; a streak counter keeps fetch from starving.
module mem_arbiter #(
   parameter int MEM_AW        = 8,
   parameter int MAX_DM_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   // fetch port
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   output logic              if_stall,
   // data port
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [31:0]       dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_ack,
   output logic [31:0]       dm_rdata,
   output logic              dm_err,
   output logic              dm_stall,
   // memory
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RSP_IF = 2'd1,
      RSP_DM = 2'd2
   } rsp_e;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

   rsp_e        rsp_q, rsp_d;
   logic        rsp_err_q, rsp_err_d;
   logic        rsp_we_q, rsp_we_d;
   logic [3:0]  streak_q, streak_d;

   logic        if_elig, dm_elig;
   logic        gnt_if, gnt_dm, gnt_any;
   logic        misal;
   logic [31:0] sel_addr;
   logic        unused_hi_addr;

   // A port sitting in its own response cycle is not eligible, so a request
   // still held high while its ack is out is not served twice.
   always_comb begin
      if_elig  = if_req & (rsp_q != RSP_IF);
      dm_elig  = dm_req & (rsp_q != RSP_DM);
      gnt_dm   = dm_elig & (~if_elig | (streak_q != STREAK_MAX));
      gnt_if   = if_elig & ~gnt_dm;
      gnt_any  = gnt_if | gnt_dm;
      sel_addr = gnt_dm ? dm_addr : if_addr;
      misal    = (sel_addr[1:0] != 2'b00);
   end

   // Misaligned grants still consume the slot but never touch memory.
   always_comb begin
      mem_en   = reset_n & gnt_any & ~misal;
      mem_we   = mem_en & gnt_dm & dm_we;
      mem_addr = sel_addr[MEM_AW+1:2];
      mem_wd   = dm_wdata;
   end

   assign unused_hi_addr = ^sel_addr[31:MEM_AW+2];

   always_comb begin
      rsp_d     = IDLE;
      rsp_err_d = 1'b0;
      rsp_we_d  = 1'b0;
      streak_d  = streak_q;
      if (gnt_dm)
         rsp_d = RSP_DM;
      else if (gnt_if)
         rsp_d = RSP_IF;
      if (gnt_any)
         rsp_err_d = misal;
      rsp_we_d = gnt_dm & dm_we;
      if (!if_req || gnt_if)
         streak_d = 4'd0;
      else if (gnt_dm && (streak_q < STREAK_MAX))
         streak_d = streak_q + 4'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_q     <= IDLE;
         rsp_err_q <= 1'b0;
         rsp_we_q  <= 1'b0;
         streak_q  <= 4'd0;
      end else begin
         rsp_q     <= rsp_d;
         rsp_err_q <= rsp_err_d;
         rsp_we_q  <= rsp_we_d;
         streak_q  <= streak_d;
      end
   end

   // Responses come straight from the registered state plus the memory's
   // one-cycle read data.
   always_comb begin
      if_ack   = (rsp_q == RSP_IF);
      dm_ack   = (rsp_q == RSP_DM);
      if_err   = if_ack & rsp_err_q;
      dm_err   = dm_ack & rsp_err_q;
      if_rdata = (if_ack && !rsp_err_q) ? mem_rd : 32'd0;
      dm_rdata = (dm_ack && !rsp_err_q && !rsp_we_q) ? mem_rd : 32'd0;
      if_stall = if_req & ~if_ack;
      dm_stall = dm_req & ~dm_ack;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset sequences, then random
// traffic checked against a transaction-level model with a shadow memory.
module tb_mem_arbiter;

   localparam int AW   = 8;
   localparam int MAXS = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          if_req, if_ack, if_err, if_stall;
   logic [31:0]   if_addr, if_rdata;
   logic          dm_req, dm_we, dm_ack, dm_err, dm_stall;
   logic [31:0]   dm_addr, dm_wdata, dm_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wd, mem_rd;

   int n_cmp = 0;
   int n_bad = 0;

   mem_arbiter #(.MEM_AW(AW), .MAX_DM_STREAK(MAXS)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .if_err(if_err), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err), .dm_stall(dm_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return (i == 5) ? 32'h2002_0005 : (32'hA500_0000 | 32'(i));
   endfunction

   // Backing memory: 1-cycle read latency, garbage on mem_rd when not reading.
   logic [31:0] bmem [256];
   bit          loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) bmem[i] <= init_word(i);
         loaded <= 1'b1;
         mem_rd <= 32'd0;
      end else begin
         if (mem_en && mem_we) bmem[mem_addr] <= mem_wd;
         if (mem_en && !mem_we) mem_rd <= bmem[mem_addr];
         else                   mem_rd <= $urandom;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        ifr;
      logic [31:0] ifa;
      logic        dmr;
      logic        we;
      logic [31:0] dma;
      logic [31:0] wd;
      logic        en;
      logic        mwe;
      logic [7:0]  maddr;
      logic        ifack;
      logic        dmack;
      logic        iferr;
      logic        dmerr;
      logic [31:0] ifrd;
      logic [31:0] dmrd;
   } vec_t;

   function automatic vec_t mk(input logic ifr, input logic [31:0] ifa,
                               input logic dmr, input logic we,
                               input logic [31:0] dma, input logic [31:0] wd,
                               input logic en, input logic mwe, input logic [7:0] maddr,
                               input logic ifack, input logic dmack,
                               input logic iferr, input logic dmerr,
                               input logic [31:0] ifrd, input logic [31:0] dmrd);
      vec_t v;
      v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.we = we; v.dma = dma; v.wd = wd;
      v.en = en; v.mwe = mwe; v.maddr = maddr; v.ifack = ifack; v.dmack = dmack;
      v.iferr = iferr; v.dmerr = dmerr; v.ifrd = ifrd; v.dmrd = dmrd;
      return v;
   endfunction

   // Reference model state: which port answers next, with what.
   int          m_rsp;      // 0 none, 1 fetch, 2 data
   logic        m_err, m_we;
   logic [31:0] m_data;
   int          m_streak;
   logic [31:0] shadow [256];

   task automatic model_step();
      int          g;
      bit          ie, de, mis, e_en, e_we, e_ifack, e_dmack;
      logic [31:0] a;
      logic [7:0]  idx;
      e_ifack = (m_rsp == 1);
      e_dmack = (m_rsp == 2);
      chk("r_if_ack",   if_ack,   e_ifack);
      chk("r_dm_ack",   dm_ack,   e_dmack);
      chk("r_if_err",   if_err,   e_ifack && m_err);
      chk("r_dm_err",   dm_err,   e_dmack && m_err);
      chk("r_if_rdata", if_rdata, (e_ifack && !m_err) ? m_data : 32'd0);
      chk("r_dm_rdata", dm_rdata, (e_dmack && !m_err && !m_we) ? m_data : 32'd0);
      chk("r_if_stall", if_stall, if_req && !e_ifack);
      chk("r_dm_stall", dm_stall, dm_req && !e_dmack);
      ie = if_req && (m_rsp != 1);
      de = dm_req && (m_rsp != 2);
      if (ie && de) g = (m_streak == MAXS) ? 1 : 2;
      else if (de)  g = 2;
      else if (ie)  g = 1;
      else          g = 0;
      a    = (g == 2) ? dm_addr : if_addr;
      mis  = (a[1:0] != 2'b00);
      idx  = a[9:2];
      e_en = (g != 0) && !mis;
      e_we = e_en && (g == 2) && dm_we;
      chk("r_mem_en", mem_en, e_en);
      chk("r_mem_we", mem_we, e_we);
      if (e_en) chk("r_mem_addr", mem_addr, idx);
      if (e_we) chk("r_mem_wd", mem_wd, dm_wdata);
      m_rsp  = g;
      m_err  = mis;
      m_we   = (g == 2) && dm_we;
      m_data = shadow[idx];
      if (e_we) shadow[idx] = dm_wdata;
      if (!if_req || g == 1) m_streak = 0;
      else if (g == 2 && m_streak < MAXS) m_streak++;
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      int          s;
      a = $urandom;
      s = $urandom_range(0, 7);
      if (s == 0) a[1:0] = 2'($urandom_range(1, 3));
      else        a[1:0] = 2'b00;
      if (s > 1)  a[31:10] = '0;
      return a;
   endfunction

   vec_t tbl[$];
   bit   if_seen, dm_seen;

   initial begin
      reset_n = 1'b0;
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;

      // Requests during reset must not reach memory or produce responses.
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h14; dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_mem_en", mem_en, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_acks",   {if_ack, dm_ack, if_err, dm_err}, 0);
         chk("rst_rdata",  if_rdata | dm_rdata, 0);
      end
      @(posedge clk); #1;
      if_req = 0; dm_req = 0; dm_we = 0;
      #2 reset_n = 1'b1;
      @(negedge clk);

      tbl.push_back(mk(1,32'h14, 0,0,0,0,           1,0,5,  0,0,0,0, 0,0));
      tbl.push_back(mk(1,32'h14, 0,0,0,0,           0,0,0,  1,0,0,0, 32'h2002_0005,0));
      tbl.push_back(mk(0,0,      0,0,0,0,           0,0,0,  0,0,0,0, 0,0));
      tbl.push_back(mk(0,0, 1,1,32'h40,32'hDEAD_BEEF, 1,1,16, 0,0,0,0, 0,0));
      tbl.push_back(mk(0,0, 1,1,32'h40,32'hDEAD_BEEF, 0,0,0,  0,1,0,0, 0,0));
      tbl.push_back(mk(0,0, 1,0,32'h40,0,           1,0,16, 0,0,0,0, 0,0));
      tbl.push_back(mk(0,0, 1,0,32'h40,0,           0,0,0,  0,1,0,0, 0,32'hDEAD_BEEF));
      tbl.push_back(mk(0,0, 1,1,32'h42,32'h1234_5678, 0,0,0, 0,0,0,0, 0,0));
      tbl.push_back(mk(0,0, 1,1,32'h42,32'h1234_5678, 0,0,0, 0,1,0,1, 0,0));
      tbl.push_back(mk(0,0, 1,0,32'h40,0,           1,0,16, 0,0,0,0, 0,0));
      tbl.push_back(mk(0,0, 1,0,32'h40,0,           0,0,0,  0,1,0,0, 0,32'hDEAD_BEEF));
      tbl.push_back(mk(1,32'h8, 1,0,32'h14,0,       1,0,5,  0,0,0,0, 0,0));
      tbl.push_back(mk(1,32'h8, 1,0,32'h14,0,       1,0,2,  0,1,0,0, 0,32'h2002_0005));
      tbl.push_back(mk(1,32'h8, 1,1,32'h24,32'hCAFE_0009, 1,1,9, 1,0,0,0, 32'hA500_0002,0));
      tbl.push_back(mk(1,32'h24, 1,1,32'h24,32'hCAFE_0009, 1,0,9, 0,1,0,0, 0,0));
      tbl.push_back(mk(1,32'h24, 0,0,0,0,           0,0,0,  1,0,0,0, 32'hCAFE_0009,0));
      tbl.push_back(mk(0,0, 1,0,32'hFFFF_FC40,0,    1,0,16, 0,0,0,0, 0,0));
      tbl.push_back(mk(0,0, 1,0,32'hFFFF_FC40,0,    0,0,0,  0,1,0,0, 0,32'hDEAD_BEEF));
      tbl.push_back(mk(1,32'h15, 0,0,0,0,           0,0,0,  0,0,0,0, 0,0));
      tbl.push_back(mk(1,32'h15, 0,0,0,0,           0,0,0,  1,0,1,0, 0,0));
      tbl.push_back(mk(0,0,      0,0,0,0,           0,0,0,  0,0,0,0, 0,0));

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         if_req = tbl[i].ifr; if_addr = tbl[i].ifa;
         dm_req = tbl[i].dmr; dm_we = tbl[i].we; dm_addr = tbl[i].dma; dm_wdata = tbl[i].wd;
         @(negedge clk);
         chk($sformatf("v%0d_mem_en", i), mem_en, tbl[i].en);
         chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].mwe);
         if (tbl[i].en)  chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].maddr);
         if (tbl[i].mwe) chk($sformatf("v%0d_mem_wd", i), mem_wd, tbl[i].wd);
         chk($sformatf("v%0d_if_ack", i),   if_ack,   tbl[i].ifack);
         chk($sformatf("v%0d_dm_ack", i),   dm_ack,   tbl[i].dmack);
         chk($sformatf("v%0d_if_err", i),   if_err,   tbl[i].iferr);
         chk($sformatf("v%0d_dm_err", i),   dm_err,   tbl[i].dmerr);
         chk($sformatf("v%0d_if_rdata", i), if_rdata, tbl[i].ifrd);
         chk($sformatf("v%0d_dm_rdata", i), dm_rdata, tbl[i].dmrd);
         chk($sformatf("v%0d_if_stall", i), if_stall, tbl[i].ifr & ~tbl[i].ifack);
         chk($sformatf("v%0d_dm_stall", i), dm_stall, tbl[i].dmr & ~tbl[i].dmack);
      end

      // Reset asserted in a grant cycle: enable drops at once, no ack follows.
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h14;
      #2 chk("mid_pre_en", mem_en, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_en_drop", mem_en, 0);
      chk("mid_we_drop", mem_we, 0);
      repeat (2) begin
         @(negedge clk);
         chk("mid_no_ack", {if_ack, dm_ack}, 0);
         chk("mid_no_en",  mem_en, 0);
      end
      #2 reset_n = 1'b1;
      #1;
      chk("post_en",   mem_en, 1);
      chk("post_addr", mem_addr, 5);
      @(negedge clk);
      chk("post_ack",   if_ack, 1);
      chk("post_rdata", if_rdata, 32'h2002_0005);
      chk("post_en2",   mem_en, 0);
      @(posedge clk); #1;
      if_req = 0;
      @(negedge clk);
      chk("post_idle", {if_ack, dm_ack, mem_en}, 0);

      // Random traffic against the model.
      for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
      shadow[16] = 32'hDEAD_BEEF;
      shadow[9]  = 32'hCAFE_0009;
      m_rsp = 0; m_err = 0; m_we = 0; m_data = 0; m_streak = 0;
      if_seen = 0; dm_seen = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (!if_req || if_seen) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = rnd_addr();
         end
         if (!dm_req || dm_seen) begin
            dm_req   = ($urandom_range(0, 3) != 0);
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = rnd_addr();
            dm_wdata = $urandom;
         end
         @(negedge clk);
         model_step();
         if_seen = if_ack;
         dm_seen = dm_ack;
      end

      @(posedge clk); #1;
      if_req = 0; dm_req = 0;
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
